ascii_operand_loader: RTL and testbench
=======================================

Name: ascii_operand_loader

Overview:
- Upstream stage of the 5-bit ripple-carry adder.
- Consumes a byte stream of ASCII decimal text, one operand per line, each line being digits followed by Enter.
- Converts the text to binary and presents an X/Y operand pair to the adder with a valid/ready handshake.
- Replaces the bench-side $fgetc digit arithmetic with synthesizable RTL.

Parameters:
- MAX_VAL, 15, largest legal operand value; range 0..31. 15 guarantees no adder overflow beyond S/C5.
- MAX_DIGITS, 2, maximum digits per operand; range 1..3.
- TERM_CHAR, 8'h0A, line terminator (Enter).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- char_valid  in  1  char_data holds a byte.
- char_data  in  8  ASCII byte.
- char_ready  out  1  block accepts a byte this cycle. A byte is accepted when char_valid && char_ready.
- op_x  out  5  operand X to adder.
- op_y  out  5  operand Y to adder.
- op_valid  out  1  op_x/op_y pair valid.
- op_ready  in  1  downstream consumes the pair. Transfer happens when op_valid && op_ready.
- err  out  1  one-cycle pulse on any rejected operand.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: char_ready=0 during reset, 1 on the first cycle after; op_x=0, op_y=0, op_valid=0, err=0. Accumulator=0, digit count=0, state=GET_X.
- Reset mid-operation: the partial operand and any held pair are discarded. No op_valid is issued.
- States:
  - GET_X: collecting X.
  - GET_Y: collecting Y.
  - FLUSH_X / FLUSH_Y: discarding bytes up to TERM_CHAR after an error. The FLUSH_* state remembers which operand to retry.
  - HOLD: pair presented.
- char_ready = 1 in GET_X, GET_Y, FLUSH_X, FLUSH_Y; 0 in HOLD.
- Accepted digit (8'h30..8'h39) in GET_*:
  - acc <= acc*10 + (char-8'h30); acc is 10 bits.
  - dcnt <= dcnt+1.
  - If dcnt == MAX_DIGITS already: pulse err, go to FLUSH_*.
- Accepted non-digit, non-TERM byte in GET_*: pulse err, go to FLUSH_*.
- Accepted TERM_CHAR in GET_*:
  - dcnt == 0: empty line, ignored, no err, stay.
  - acc > MAX_VAL: pulse err, clear acc/dcnt, stay in the same GET_* state (re-enter the same operand).
  - Otherwise, in GET_X: op_x <= acc[4:0], go to GET_Y.
  - Otherwise, in GET_Y: op_y <= acc[4:0], op_valid <= 1, go to HOLD.
  - acc and dcnt are cleared on every TERM_CHAR.
- FLUSH_*: every accepted byte is dropped. TERM_CHAR returns to the matching GET_* state with acc/dcnt cleared. No further err pulses are issued while in FLUSH_*.
- err is registered: high exactly the cycle after the offending byte is accepted.
- Latency: Y's TERM_CHAR accepted at edge n → op_valid=1 after edge n; the adder's combinational result follows.
- HOLD:
  - op_x, op_y and op_valid stay stable until op_valid && op_ready.
  - On that edge: op_valid <= 0, state <= GET_X, char_ready=1 next cycle. op_x/op_y keep their last values.
  - If op_ready is already high on HOLD entry, the transfer completes on the next edge (pair valid exactly one cycle).
- Leading zeros count as digits ("07" is 2 digits, value 7).

Optional Feature:
- Macro ASCII_CR_IGNORE_EN.
- Defined: byte 8'h0D is accepted and silently dropped in every non-HOLD state (no err, acc/dcnt unchanged). CRLF input is therefore tolerated.
- Undefined: 8'h0D is an ordinary non-digit, giving an err pulse and a flush.

Decomposition:
- Shared package ascii_pkg holds:
  - constants ASCII_ZERO=8'h30, ASCII_NINE=8'h39, ASCII_LF=8'h0A, ASCII_CR=8'h0D.
  - state enum loader_state_t {GET_X, GET_Y, FLUSH_X, FLUSH_Y, HOLD}.
- One natural sub-module, ascii_char_class: combinational; outputs is_digit, is_term, is_cr and digit value [3:0]. It is reused by later text-output stages.

Test Plan:
- "0","7",LF,"1","2",LF with op_ready=1 → op_valid one cycle; op_x=5'b00111, op_y=5'b01100; adder S=19, C5=0; err never high.
- "1","6",LF → err pulse; X re-entered with "1","5",LF; then Y "1","5",LF → op_x=15, op_y=15, S=5'b11110.
- "1","A","3",LF,"0","4",LF → err after 'A'; "3" flushed; "04" is taken as X=4, with Y still pending (no op_valid).
- "1","2","3",LF → err on third digit; LF ends the flush; then "09",LF,"01",LF → pair (9,1).
- op_ready=0 for 10 cycles after the pair → op_valid and operands stable; char_ready=0 and char_valid bytes ignored. Raise op_ready → single transfer. rst asserted mid-X → all outputs are zero next cycle.
- With ASCII_CR_IGNORE_EN: "3",CR,LF,"4",CR,LF → pair (3,4), no err. Without it → err pulse after each CR.

Source files
------------

// File: rtl/ascii_pkg.sv
// Shared constants and the loader state encoding for the ASCII text stages.
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;

    typedef enum logic [2:0] {
        GET_X,
        GET_Y,
        FLUSH_X,
        FLUSH_Y,
        HOLD
    } loader_state_t;

endpackage

// File: rtl/ascii_operand_loader_if.sv
// Byte-stream input and operand-pair output of the ASCII operand loader.
interface ascii_operand_loader_if;

    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic [4:0] op_x;
    logic [4:0] op_y;
    logic       op_valid;
    logic       op_ready;
    logic       err;

    // master: the loader itself; slave: the byte source / adder side.
    modport master (
        input  char_valid,
        input  char_data,
        output char_ready,
        output op_x,
        output op_y,
        output op_valid,
        input  op_ready,
        output err
    );

    modport slave (
        output char_valid,
        output char_data,
        input  char_ready,
        input  op_x,
        input  op_y,
        input  op_valid,
        output op_ready,
        input  err
    );

endinterface

// File: rtl/ascii_char_class.sv
// Combinational classifier for one ASCII byte: decimal digit, line terminator or CR.
module ascii_char_class
    import ascii_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = ASCII_LF
) (
    input  logic [7:0] char_byte,
    output logic       is_digit,
    output logic       is_term,
    output logic       is_cr,
    output logic [3:0] digit
);

    assign is_digit = (char_byte >= ASCII_ZERO) && (char_byte <= ASCII_NINE);
    assign is_term  = (char_byte == TERM_CHAR);
    assign is_cr    = (char_byte == ASCII_CR);
    // The low nibble of '0'..'9' is already the digit value.
    assign digit    = char_byte[3:0];

endmodule

// File: rtl/ascii_operand_loader.sv
// Parses decimal text lines into an X/Y operand pair with a valid/ready handshake.
// Build option: define ASCII_CR_IGNORE_EN to silently drop CR bytes (CRLF tolerance).
module ascii_operand_loader
    import ascii_pkg::*;
#(
    parameter int         MAX_VAL    = 15,
    parameter int         MAX_DIGITS = 2,
    parameter logic [7:0] TERM_CHAR  = ASCII_LF
) (
    input  logic                   clk,
    input  logic                   rst,
    ascii_operand_loader_if.master bus
);

    localparam logic [9:0] MAX_ACC  = 10'(MAX_VAL);
    localparam logic [1:0] MAX_DCNT = 2'(MAX_DIGITS);
`ifdef ASCII_CR_IGNORE_EN
    localparam logic CR_IGNORE = 1'b1;
`else
    localparam logic CR_IGNORE = 1'b0;
`endif

    loader_state_t state_q, state_d;
    logic [9:0]    acc_q, acc_d;
    logic [1:0]    dcnt_q, dcnt_d;
    logic [4:0]    op_x_q, op_x_d;
    logic [4:0]    op_y_q, op_y_d;
    logic          op_valid_q, op_valid_d;
    logic          err_q, err_d;

    logic          is_digit, is_term, is_cr;
    logic [3:0]    digit;
    logic          char_ready;
    logic          char_accept;
    logic          cr_drop;
    loader_state_t flush_state;

    ascii_char_class #(
        .TERM_CHAR (TERM_CHAR)
    ) u_class (
        .char_byte (bus.char_data),
        .is_digit  (is_digit),
        .is_term   (is_term),
        .is_cr     (is_cr),
        .digit     (digit)
    );

    assign char_ready  = !rst && (state_q != HOLD);
    assign char_accept = bus.char_valid && char_ready;
    assign cr_drop     = is_cr && CR_IGNORE;
    assign flush_state = (state_q == GET_X) ? FLUSH_X : FLUSH_Y;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        dcnt_d     = dcnt_q;
        op_x_d     = op_x_q;
        op_y_d     = op_y_q;
        op_valid_d = op_valid_q;
        err_d      = 1'b0;

        case (state_q)
            GET_X, GET_Y: begin
                if (char_accept && !cr_drop) begin
                    if (is_digit) begin
                        if (dcnt_q == MAX_DCNT) begin
                            err_d   = 1'b1;
                            acc_d   = '0;
                            dcnt_d  = '0;
                            state_d = flush_state;
                        end else begin
                            acc_d  = acc_q * 10'd10 + {6'd0, digit};
                            dcnt_d = dcnt_q + 2'd1;
                        end
                    end else if (is_term) begin
                        acc_d  = '0;
                        dcnt_d = '0;
                        // An empty line is simply skipped.
                        if (dcnt_q != 2'd0) begin
                            if (acc_q > MAX_ACC) begin
                                err_d = 1'b1;
                            end else if (state_q == GET_X) begin
                                op_x_d  = acc_q[4:0];
                                state_d = GET_Y;
                            end else begin
                                op_y_d     = acc_q[4:0];
                                op_valid_d = 1'b1;
                                state_d    = HOLD;
                            end
                        end
                    end else begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        dcnt_d  = '0;
                        state_d = flush_state;
                    end
                end
            end
            FLUSH_X, FLUSH_Y: begin
                if (char_accept && is_term) begin
                    acc_d   = '0;
                    dcnt_d  = '0;
                    state_d = (state_q == FLUSH_X) ? GET_X : GET_Y;
                end
            end
            HOLD: begin
                if (bus.op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = GET_X;
                end
            end
            default: begin
                state_d = GET_X;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= GET_X;
            acc_q      <= '0;
            dcnt_q     <= '0;
            op_x_q     <= '0;
            op_y_q     <= '0;
            op_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            dcnt_q     <= dcnt_d;
            op_x_q     <= op_x_d;
            op_y_q     <= op_y_d;
            op_valid_q <= op_valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.char_ready = char_ready;
    assign bus.op_x       = op_x_q;
    assign bus.op_y       = op_y_q;
    assign bus.op_valid   = op_valid_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_ascii_operand_loader.sv
// Directed bench for ascii_operand_loader: text lines in, operand pairs and err pulses checked.
module tb_ascii_operand_loader;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    ascii_operand_loader_if bus ();

    ascii_operand_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one byte, wait (bounded) until it is accepted, then check err one cycle later.
    task automatic send(input logic [7:0] b, input logic exp_err, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        bus.char_valid = 1'b1;
        bus.char_data  = b;
        while (bus.char_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_timeout"}, 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    endtask

    task automatic check_pair(input string tag, input logic [4:0] x, input logic [4:0] y);
        chk({tag, "_op_valid"}, 32'(bus.op_valid), 32'd1);
        chk({tag, "_op_x"}, 32'(bus.op_x), 32'(x));
        chk({tag, "_op_y"}, 32'(bus.op_y), 32'(y));
    endtask

    initial begin
        n_checks       = 0;
        n_fails        = 0;
        rst            = 1'b1;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        bus.op_ready   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_char_ready", 32'(bus.char_ready), 32'd0);
        chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
        chk("rst_op_x", 32'(bus.op_x), 32'd0);
        chk("rst_op_y", 32'(bus.op_y), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_char_ready", 32'(bus.char_ready), 32'd1);

        // "07","12" with op_ready already high: pair valid for exactly one cycle
        bus.op_ready = 1'b1;
        send(8'h0A, 1'b0, "t1_empty_lf");
        send("0", 1'b0, "t1_0");
        send("7", 1'b0, "t1_7");
        send(8'h0A, 1'b0, "t1_lfx");
        chk("t1_no_valid_after_x", 32'(bus.op_valid), 32'd0);
        send("1", 1'b0, "t1_1");
        send("2", 1'b0, "t1_2");
        send(8'h0A, 1'b0, "t1_lfy");
        check_pair("t1", 5'd7, 5'd12);
        chk("t1_char_ready_hold", 32'(bus.char_ready), 32'd0);
        chk("t1_adder_sum", 32'({1'b0, bus.op_x} + {1'b0, bus.op_y}), 32'd19);
        @(posedge clk);
        #1;
        chk("t1_valid_dropped", 32'(bus.op_valid), 32'd0);
        chk("t1_char_ready_back", 32'(bus.char_ready), 32'd1);
        chk("t1_op_x_kept", 32'(bus.op_x), 32'd7);

        // X=16 rejected, X re-entered as 15, Y=15
        send("1", 1'b0, "t2_1");
        send("6", 1'b0, "t2_6");
        send(8'h0A, 1'b1, "t2_lf_over");
        send("1", 1'b0, "t2_1b");
        send("5", 1'b0, "t2_5");
        send(8'h0A, 1'b0, "t2_lfx");
        send("1", 1'b0, "t2_1y");
        send("5", 1'b0, "t2_5y");
        send(8'h0A, 1'b0, "t2_lfy");
        check_pair("t2", 5'd15, 5'd15);
        chk("t2_adder_sum", 32'({1'b0, bus.op_x} + {1'b0, bus.op_y}), 32'd30);
        @(posedge clk);
        #1;
        chk("t2_valid_dropped", 32'(bus.op_valid), 32'd0);

        // Bad character: flush to LF, then "04" becomes X, Y still pending
        send("1", 1'b0, "t3_1");
        send("A", 1'b1, "t3_A");
        send("3", 1'b0, "t3_3_flushed");
        send(8'h0A, 1'b0, "t3_lf_flush");
        send("0", 1'b0, "t3_0");
        send("4", 1'b0, "t3_4");
        send(8'h0A, 1'b0, "t3_lfx");
        chk("t3_no_valid", 32'(bus.op_valid), 32'd0);
        chk("t3_op_x", 32'(bus.op_x), 32'd4);
        send("0", 1'b0, "t3_0y");
        send(8'h0A, 1'b0, "t3_lfy");
        check_pair("t3", 5'd4, 5'd0);
        @(posedge clk);
        #1;

        // Too many digits, then pair (9,1) held with op_ready low
        bus.op_ready = 1'b0;
        send("1", 1'b0, "t4_1");
        send("2", 1'b0, "t4_2");
        send("3", 1'b1, "t4_3_third");
        send(8'h0A, 1'b0, "t4_lf_flush");
        send("0", 1'b0, "t4_0");
        send("9", 1'b0, "t4_9");
        send(8'h0A, 1'b0, "t4_lfx");
        send("0", 1'b0, "t4_0y");
        send("1", 1'b0, "t4_1y");
        send(8'h0A, 1'b0, "t4_lfy");
        check_pair("t4", 5'd9, 5'd1);
        @(negedge clk);
        bus.char_valid = 1'b1;
        bus.char_data  = "5";
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_pair($sformatf("t5_hold%0d", i), 5'd9, 5'd1);
            chk($sformatf("t5_hold%0d_char_ready", i), 32'(bus.char_ready), 32'd0);
        end
        @(negedge clk);
        bus.char_valid = 1'b0;
        bus.op_ready   = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_transfer", 32'(bus.op_valid), 32'd0);
        chk("t5_op_y_kept", 32'(bus.op_y), 32'd1);
        @(negedge clk);
        bus.op_ready = 1'b0;
        // Bytes offered during HOLD must not have been taken as digits
        send("2", 1'b0, "t5_2");
        send(8'h0A, 1'b0, "t5_lfx");
        chk("t5_op_x_fresh", 32'(bus.op_x), 32'd2);
        chk("t5_no_valid", 32'(bus.op_valid), 32'd0);

        // Reset mid-X discards partial operand and held values
        send("3", 1'b0, "t6_3");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_op_x", 32'(bus.op_x), 32'd0);
        chk("t6_rst_op_y", 32'(bus.op_y), 32'd0);
        chk("t6_rst_op_valid", 32'(bus.op_valid), 32'd0);
        chk("t6_rst_err", 32'(bus.err), 32'd0);
        chk("t6_rst_char_ready", 32'(bus.char_ready), 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.op_ready = 1'b1;
        send("1", 1'b0, "t6_1x");
        send(8'h0A, 1'b0, "t6_lfx");
        send("1", 1'b0, "t6_1y");
        send(8'h0A, 1'b0, "t6_lfy");
        check_pair("t6", 5'd1, 5'd1);
        @(posedge clk);
        #1;

        // CRLF line endings
`ifdef ASCII_CR_IGNORE_EN
        send("3", 1'b0, "t7_3");
        send(8'h0D, 1'b0, "t7_crx");
        send(8'h0A, 1'b0, "t7_lfx");
        send("4", 1'b0, "t7_4");
        send(8'h0D, 1'b0, "t7_cry");
        send(8'h0A, 1'b0, "t7_lfy");
        check_pair("t7", 5'd3, 5'd4);
`else
        send("3", 1'b0, "t7_3");
        send(8'h0D, 1'b1, "t7_crx");
        send(8'h0A, 1'b0, "t7_lfx");
        send("4", 1'b0, "t7_4");
        send(8'h0D, 1'b1, "t7_cry");
        send(8'h0A, 1'b0, "t7_lfy");
        chk("t7_no_valid", 32'(bus.op_valid), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
